// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Dynamic branch predictor placed at the fetch/execute boundary. It holds a
// direct-mapped table of 2-bit saturating counters with branch targets.
//
//   Fetch side (combinational, same cycle):
//     if_pc           - fetch PC to look up
//     pred_taken      - predicted direction for if_pc
//     pred_target     - predicted next PC for if_pc (if_pc+4 when not taken)
//
//   Execute side (one resolved conditional branch per cycle at most):
//     upd_valid       - a resolved branch is present this cycle
//     upd_pc          - PC of the resolved branch
//     upd_taken       - resolved direction
//     upd_target      - computed branch target
//     upd_pred_taken  - direction that was predicted for this branch
//     upd_pred_target - next PC that was predicted for this branch
//     mispredict      - flush request for this update (combinational)
//     redirect_pc     - correct next PC, meaningful when mispredict=1
//
//   Performance:
//     perf_branches    - count of resolved branches (wraps)
//     perf_mispredicts - count of mispredicts (wraps)
//
// Reset is synchronous and active-low (rst_n). Lookups read the registered
// table only, so an update is visible to fetch from the following cycle.
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    // Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
    localparam logic [1:0] CTR_WEAK_NT = 2'b01;
    localparam logic [1:0] CTR_WEAK_T  = 2'b10;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];

    // -------------------------------------------------------------------------
    // Fetch-side lookup
    // -------------------------------------------------------------------------
    logic [INDEX_BITS-1:0] if_idx;
    logic [TAG_BITS-1:0]   if_tag;
    logic                  if_hit;

    assign if_idx      = if_pc[INDEX_BITS+1:2];
    assign if_tag      = if_pc[TAG_HI:TAG_LO];
    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = if_hit && ctr_q[if_idx][1];
    assign pred_target = pred_taken ? target_q[if_idx] : if_pc + 32'd4;

    // -------------------------------------------------------------------------
    // Execute-side resolution
    // -------------------------------------------------------------------------
    logic [INDEX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0]   upd_tag;
    logic                  upd_hit;

    assign upd_idx = upd_pc[INDEX_BITS+1:2];
    assign upd_tag = upd_pc[TAG_HI:TAG_LO];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // A taken branch whose predicted target differs is a mispredict even
    // when the direction was right; a not-taken branch has no target to miss.
    assign mispredict  = upd_valid &&
                         ((upd_taken != upd_pred_taken) ||
                          (upd_taken && (upd_target != upd_pred_target)));
    assign redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;

    // PC bits outside the index/tag fields (byte offset, high bits) are
    // intentionally ignored by the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc, upd_pc};

    // -------------------------------------------------------------------------
    // Table training and performance counters
    // -------------------------------------------------------------------------
    // NOTE: the table is a register array, not a RAM macro, because every
    // entry must return to a known state on reset; the loop clears all of it.
    // NOTE: all state here uses non-blocking assignments so the lookup above
    // always sees pre-edge contents, giving the required no-bypass behaviour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                ctr_q[i]    <= CTR_WEAK_NT;
                target_q[i] <= '0;
            end
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else if (upd_valid) begin
            perf_branches <= perf_branches + 32'd1;
            if (mispredict) begin
                perf_mispredicts <= perf_mispredicts + 32'd1;
            end

            if (upd_hit) begin
                if (upd_taken) begin
                    if (ctr_q[upd_idx] != 2'b11) begin
                        ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
                    end
                    target_q[upd_idx] <= upd_target;
                end else if (ctr_q[upd_idx] != 2'b00) begin
                    ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Allocate on a taken miss, evicting whatever aliased here.
                // Not-taken misses leave the table alone.
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                ctr_q[upd_idx]    <= CTR_WEAK_T;
                target_q[upd_idx] <= upd_target;
            end
        end
    end

endmodule
